if_fetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of the program counter. Samples the current PC and issues a read to instruction memory over a req/gnt/rvalid handshake. Buffers returned instructions with their PCs in a small FIFO for decode, and returns a one-cycle pc_advance pulse to the next-PC logic. Drops in-flight and buffered fetches on a jump/branch redirect (flush).

---
 rtl/if_fetch_unit.sv | 102 ++++++++++
 tb/tb_if_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage between the PC register and decode
//   Clk, reset          clock, async active-high reset
//   pc_in, pc_advance   current PC in, one-cycle "request accepted" pulse out
//   flush               redirect: drop in-flight and buffered fetches
//   imem_*              req/gnt/rvalid read port, one request outstanding
//   out_*               FIFO head {pc, instr, misalign} with valid/ready
module if_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t            state;
  logic [ADDR_W-1:0] req_pc;
  logic              drop, halted;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] ins_mem [DEPTH];
  logic [DEPTH-1:0]  mis_mem;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count, cnt_post;
  logic aligned, pop, rx, push_data, idle_go, push_mis, push, issue_idle, issue_wait;
  assign imem_req     = state == REQ;
  assign imem_addr    = req_pc;
  assign pc_advance   = imem_req & imem_gnt;
  assign out_valid    = count != '0;
  assign out_pc       = pc_mem[rd_ptr];
  assign out_instr    = ins_mem[rd_ptr];
  assign out_misalign = mis_mem[rd_ptr];
  // A misaligned PC seen in WAIT falls back to IDLE, which then pushes the
  // marker; this keeps the FIFO to a single write per cycle.
  always_comb begin
    aligned    = pc_in[1:0] == 2'b00;
    pop        = out_valid & out_ready & ~flush;
    rx         = (state == WAIT) & imem_rvalid;
    push_data  = rx & ~drop & ~flush;
    idle_go    = (state == IDLE) & ~flush & ~halted & (count < FULL);
    push_mis   = idle_go & ~aligned;
    issue_idle = idle_go & aligned;
    push       = push_data | push_mis;
    cnt_post   = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    issue_wait = rx & ~flush & ~halted & aligned & (cnt_post < FULL);
  end
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      req_pc  <= '0;
      drop    <= 1'b0;
      halted  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      mis_mem <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        pc_mem[wr_ptr]  <= push_mis ? pc_in : req_pc;
        ins_mem[wr_ptr] <= push_mis ? '0 : imem_rdata;
        mis_mem[wr_ptr] <= push_mis;
      end
      wr_ptr <= flush ? '0 : push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= flush ? '0 : pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= flush ? '0 : cnt_post;
      halted <= flush ? 1'b0 : halted | push_mis;
      case (state)
        IDLE: if (issue_idle) begin
          state  <= REQ;
          req_pc <= pc_in;
        end
        REQ: if (imem_gnt) begin
          state <= WAIT;
          drop  <= flush;
        end else if (flush) state <= IDLE;
        WAIT: if (imem_rvalid) begin
          drop   <= 1'b0;
          state  <= issue_wait ? REQ : IDLE;
          req_pc <= issue_wait ? pc_in : req_pc;
        end else if (flush) drop <= 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: vector, corner-sequence and randomized checks of if_fetch_unit
module tb_if_fetch_unit;
  logic        Clk = 1'b0, reset = 1'b1, flush = 1'b0, pc_advance;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, out_valid, out_ready = 1'b0, out_misalign;
  logic [31:0] pc_in = '0, imem_addr, imem_rdata = '0, out_instr, out_pc;
  int          errs = 0, checks = 0;
  typedef struct {
    logic fl; logic [31:0] pc; logic g, rv; logic [31:0] ra; logic rdy;
    logic e_req; logic [31:0] e_addr; logic e_adv, e_val; logic [31:0] e_pc; logic e_mis;
  } vec_t;
  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  logic [31:0] mpc, pend_addr;
  int          g_wait, rv_wait, popped;
  bit          have_pend;

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .Clk(Clk), .reset(reset), .pc_in(pc_in), .flush(flush), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_misalign(out_misalign)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  function automatic vec_t mk(input logic fl, input logic [31:0] pc, input logic g, input logic rv,
                              input logic [31:0] ra, input logic rdy, input logic e_req,
                              input logic [31:0] e_addr, input logic e_adv, input logic e_val,
                              input logic [31:0] e_pc, input logic e_mis);
    vec_t v;
    v.fl = fl; v.pc = pc; v.g = g; v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_adv = e_adv; v.e_val = e_val; v.e_pc = e_pc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic rst();
    reset = 1'b1; flush = 1'b0; pc_in = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; out_ready = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    reset = 1'b0;
    #1;
    chk("rst.req", 32'(imem_req), 0);
    chk("rst.addr", imem_addr, 0);
    chk("rst.adv", 32'(pc_advance), 0);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.pc", out_pc, 0);
    chk("rst.instr", out_instr, 0);
    chk("rst.mis", 32'(out_misalign), 0);
  endtask

  task automatic vec(input string tag, input vec_t v);
    flush = v.fl; pc_in = v.pc; imem_gnt = v.g; imem_rvalid = v.rv;
    imem_rdata = v.rv ? fn(v.ra) : '0; out_ready = v.rdy;
    #1;
    chk({tag, ".req"}, 32'(imem_req), 32'(v.e_req));
    if (v.e_req) chk({tag, ".addr"}, imem_addr, v.e_addr);
    chk({tag, ".adv"}, 32'(pc_advance), 32'(v.e_adv));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v.e_val));
    if (v.e_val) begin
      chk({tag, ".pc"}, out_pc, v.e_pc);
      chk({tag, ".instr"}, out_instr, v.e_mis ? 32'h0 : fn(v.e_pc));
      chk({tag, ".mis"}, 32'(out_misalign), 32'(v.e_mis));
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    // stream 0/4/8, backpressure fills both entries, delayed grant on 0x10
    //             fl pc     g rv ra     rdy  req addr  adv val pc    mis
    tbl.push_back(mk(0, 'h00, 0, 0, 'h00, 1,   0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h00, 1, 0, 'h00, 1,   1, 'h00, 1, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h04, 0, 1, 'h00, 1,   0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h04, 1, 0, 'h00, 1,   1, 'h04, 1, 1, 'h00, 0));
    tbl.push_back(mk(0, 'h08, 0, 1, 'h04, 1,   0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h08, 1, 0, 'h00, 1,   1, 'h08, 1, 1, 'h04, 0));
    tbl.push_back(mk(0, 'h0C, 0, 1, 'h08, 0,   0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h0C, 1, 0, 'h00, 0,   1, 'h0C, 1, 1, 'h08, 0));
    tbl.push_back(mk(0, 'h10, 0, 1, 'h0C, 0,   0, 'h00, 0, 1, 'h08, 0));
    tbl.push_back(mk(0, 'h10, 0, 0, 'h00, 0,   0, 'h00, 0, 1, 'h08, 0));
    tbl.push_back(mk(0, 'h10, 0, 0, 'h00, 0,   0, 'h00, 0, 1, 'h08, 0));
    tbl.push_back(mk(0, 'h10, 0, 0, 'h00, 1,   0, 'h00, 0, 1, 'h08, 0));
    tbl.push_back(mk(0, 'h10, 0, 0, 'h00, 1,   0, 'h00, 0, 1, 'h0C, 0));
    tbl.push_back(mk(0, 'h10, 0, 0, 'h00, 1,   1, 'h10, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h14, 0, 0, 'h00, 1,   1, 'h10, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h14, 0, 0, 'h00, 1,   1, 'h10, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h14, 1, 0, 'h00, 1,   1, 'h10, 1, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h14, 0, 1, 'h10, 1,   0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h14, 0, 0, 'h00, 1,   1, 'h14, 0, 1, 'h10, 0));
    rst();
    foreach (tbl[i]) vec($sformatf("tbl[%0d]", i), tbl[i]);

    // flush while waiting for 0x20 with 0x18 buffered
    rst();
    vec("fw0", mk(0, 'h018, 0, 0, 'h000, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fw1", mk(0, 'h018, 1, 0, 'h000, 0,  1, 'h018, 1, 0, 'h000, 0));
    vec("fw2", mk(0, 'h020, 0, 1, 'h018, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fw3", mk(0, 'h020, 1, 0, 'h000, 0,  1, 'h020, 1, 1, 'h018, 0));
    vec("fw4", mk(1, 'h100, 0, 0, 'h000, 0,  0, 'h000, 0, 1, 'h018, 0));
    vec("fw5", mk(0, 'h100, 0, 1, 'h020, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fw6", mk(0, 'h100, 1, 0, 'h000, 0,  1, 'h100, 1, 0, 'h000, 0));
    vec("fw7", mk(0, 'h104, 0, 1, 'h100, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fw8", mk(0, 'h104, 0, 0, 'h000, 1,  1, 'h104, 0, 1, 'h100, 0));

    // flush coincident with grant
    rst();
    vec("fg0", mk(0, 'h030, 0, 0, 'h000, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fg1", mk(1, 'h030, 1, 0, 'h000, 0,  1, 'h030, 1, 0, 'h000, 0));
    vec("fg2", mk(0, 'h200, 0, 1, 'h030, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fg3", mk(0, 'h200, 1, 0, 'h000, 0,  1, 'h200, 1, 0, 'h000, 0));
    vec("fg4", mk(0, 'h204, 0, 1, 'h200, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fg5", mk(0, 'h204, 0, 0, 'h000, 1,  1, 'h204, 0, 1, 'h200, 0));

    // flush withdrawing an ungranted request, then flush coincident with rvalid
    rst();
    vec("fr0", mk(0, 'h070, 0, 0, 'h000, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fr1", mk(1, 'h070, 0, 0, 'h000, 0,  1, 'h070, 0, 0, 'h000, 0));
    vec("fr2", mk(0, 'h080, 0, 0, 'h000, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fr3", mk(0, 'h080, 1, 0, 'h000, 0,  1, 'h080, 1, 0, 'h000, 0));
    vec("fr4", mk(1, 'h300, 0, 1, 'h080, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fr5", mk(0, 'h300, 0, 0, 'h000, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fr6", mk(0, 'h300, 1, 0, 'h000, 0,  1, 'h300, 1, 0, 'h000, 0));
    vec("fr7", mk(0, 'h304, 0, 1, 'h300, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("fr8", mk(0, 'h304, 0, 0, 'h000, 1,  1, 'h304, 0, 1, 'h300, 0));

    // misaligned PC halts fetch until a flush
    rst();
    vec("ma0", mk(0, 'h006, 0, 0, 'h000, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("ma1", mk(0, 'h006, 0, 0, 'h000, 0,  0, 'h000, 0, 1, 'h006, 1));
    vec("ma2", mk(0, 'h040, 0, 0, 'h000, 0,  0, 'h000, 0, 1, 'h006, 1));
    vec("ma3", mk(1, 'h040, 0, 0, 'h000, 1,  0, 'h000, 0, 1, 'h006, 1));
    vec("ma4", mk(0, 'h040, 0, 0, 'h000, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("ma5", mk(0, 'h040, 1, 0, 'h000, 0,  1, 'h040, 1, 0, 'h000, 0));
    vec("ma6", mk(0, 'h044, 0, 1, 'h040, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("ma7", mk(0, 'h044, 0, 0, 'h000, 1,  1, 'h044, 0, 1, 'h040, 0));

    // reset mid-WAIT, then a stray rvalid must be ignored
    rst();
    vec("rw0", mk(0, 'h050, 0, 0, 'h000, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("rw1", mk(0, 'h050, 1, 0, 'h000, 0,  1, 'h050, 1, 0, 'h000, 0));
    rst();
    vec("rw2", mk(0, 'h060, 0, 1, 'h050, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("rw3", mk(0, 'h060, 1, 0, 'h000, 0,  1, 'h060, 1, 0, 'h000, 0));
    vec("rw4", mk(0, 'h064, 0, 1, 'h060, 0,  0, 'h000, 0, 0, 'h000, 0));
    vec("rw5", mk(0, 'h064, 0, 0, 'h000, 1,  1, 'h064, 0, 1, 'h060, 0));

    // randomized memory timing and backpressure against an in-order PC stream model
    rst();
    mpc = 32'h1000; pc_in = mpc; g_wait = 0; have_pend = 0; popped = 0;
    for (int c = 0; c < 1000; c++) begin
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; flush = 1'b0;
      out_ready = $urandom_range(0, 3) != 0;
      if (have_pend) begin
        if (rv_wait == 0) begin
          imem_rvalid = 1'b1; imem_rdata = fn(pend_addr); have_pend = 0;
        end else rv_wait--;
      end else if (imem_req) begin
        if (g_wait == 0) begin
          imem_gnt = 1'b1; have_pend = 1; pend_addr = imem_addr;
          rv_wait = int'($urandom_range(0, 2)); g_wait = int'($urandom_range(0, 3));
        end else g_wait--;
      end
      if (imem_req) chk("rnd.addr", imem_addr, mpc);
      #1;
      chk("rnd.adv", 32'(pc_advance), 32'(imem_gnt));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rnd.spurious", 32'(out_valid), 0);
        else begin
          chk("rnd.pc", out_pc, exp_q[0]);
          chk("rnd.instr", out_instr, fn(exp_q[0]));
          chk("rnd.mis", 32'(out_misalign), 0);
          void'(exp_q.pop_front());
          popped++;
        end
      end
      if (pc_advance) begin
        exp_q.push_back(mpc);
        mpc += 32'd4;
        pc_in = mpc;
      end
      chk("rnd.credit", 32'(exp_q.size() <= 2), 1);
      @(posedge Clk); #1;
    end
    chk("rnd.progress", 32'(popped >= 100), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
